// File: rtl/ge_p3_to_cached_if.sv
// rtl/ge_p3_to_cached_if.sv - point in/out and shared field-unit bus for ge_p3_to_cached
interface ge_p3_to_cached_if;
  logic         valid;
  logic [319:0] p_x, p_y, p_z, p_t;
  logic         p_error;
  logic [319:0] c_yplusx, c_yminusx, c_z, c_t2d;
  logic         error, done, busy;
  logic [319:0] mul_op_a, mul_op_b, mul_res;
  logic         mul_valid, mul_done;
  logic [319:0] add_op_a, add_op_b, add_res;
  logic [319:0] sub_op_a, sub_op_b, sub_res;

  modport slave (
    input  valid, p_x, p_y, p_z, p_t, p_error,
    input  mul_res, mul_done, add_res, sub_res,
    output c_yplusx, c_yminusx, c_z, c_t2d, error, done, busy,
    output mul_op_a, mul_op_b, mul_valid,
    output add_op_a, add_op_b, sub_op_a, sub_op_b
  );

  modport master (
    output valid, p_x, p_y, p_z, p_t, p_error,
    output mul_res, mul_done, add_res, sub_res,
    input  c_yplusx, c_yminusx, c_z, c_t2d, error, done, busy,
    input  mul_op_a, mul_op_b, mul_valid,
    input  add_op_a, add_op_b, sub_op_a, sub_op_b
  );
endinterface

// File: rtl/ge_p3_to_cached.sv
// rtl/ge_p3_to_cached.sv - extended point to cached form using shared fe units
// Optional GE_CACHED_RECOMPUTE_T_EN: recompute T as X*Y instead of using p_t.
module ge_p3_to_cached #(
  parameter int unsigned MUL_TIMEOUT = 0
) (
  input logic           clk,
  input logic           rst,
  ge_p3_to_cached_if.slave bus
);

  localparam logic [319:0] D2 = {
    32'sd9444199, 32'sd29715968, -32'sd6495438, -32'sd12551817, 32'sd15978800,
    32'sd229458, 32'sd13898782, -32'sd30745221, -32'sd5839606, -32'sd21827239
  };

  typedef enum logic [2:0] {
    IDLE,
    ADDSUB,
`ifdef GE_CACHED_RECOMPUTE_T_EN
    MUL_T,
    MUL_T_WAIT,
`endif
    MUL_ISSUE,
    MUL_WAIT,
    FIN
  } state_t;

  state_t       state, state_n;
  logic [319:0] x, y, z, t;
  logic [319:0] c_yplusx, c_yminusx, c_z, c_t2d;
  logic         error;
  logic [31:0]  cnt;
  logic         cnt_clr;
  logic         timeout;

  // cnt counts cycles since the multiply was issued, issue cycle included
  assign timeout = (MUL_TIMEOUT != 0) && (cnt >= MUL_TIMEOUT - 1);

  always_comb begin
    state_n       = state;
    bus.mul_valid = 1'b0;
    bus.mul_op_a  = '0;
    bus.mul_op_b  = '0;
    bus.add_op_a  = '0;
    bus.add_op_b  = '0;
    bus.sub_op_a  = '0;
    bus.sub_op_b  = '0;
    case (state)
      IDLE: if (bus.valid) state_n = bus.p_error ? FIN : ADDSUB;
      ADDSUB: begin
        bus.add_op_a = y;
        bus.add_op_b = x;
        bus.sub_op_a = y;
        bus.sub_op_b = x;
`ifdef GE_CACHED_RECOMPUTE_T_EN
        state_n = MUL_T;
`else
        state_n = MUL_ISSUE;
`endif
      end
`ifdef GE_CACHED_RECOMPUTE_T_EN
      MUL_T: begin
        bus.mul_valid = 1'b1;
        bus.mul_op_a  = x;
        bus.mul_op_b  = y;
        state_n       = MUL_T_WAIT;
      end
      MUL_T_WAIT: begin
        bus.mul_op_a = x;
        bus.mul_op_b = y;
        if (bus.mul_done) state_n = MUL_ISSUE;
        else if (timeout) state_n = FIN;
      end
`endif
      MUL_ISSUE: begin
        bus.mul_valid = 1'b1;
        bus.mul_op_a  = t;
        bus.mul_op_b  = D2;
        state_n       = MUL_WAIT;
      end
      MUL_WAIT: begin
        bus.mul_op_a = t;
        bus.mul_op_b = D2;
        if (bus.mul_done || timeout) state_n = FIN;
      end
      FIN:     state_n = IDLE;
      default: state_n = IDLE;
    endcase
  end

`ifdef GE_CACHED_RECOMPUTE_T_EN
  assign cnt_clr = (state_n == MUL_ISSUE) || (state_n == MUL_T);
`else
  assign cnt_clr = (state_n == MUL_ISSUE);
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      x         <= '0;
      y         <= '0;
      z         <= '0;
      t         <= '0;
      c_yplusx  <= '0;
      c_yminusx <= '0;
      c_z       <= '0;
      c_t2d     <= '0;
      error     <= 1'b0;
      cnt       <= '0;
    end else begin
      state <= state_n;
      cnt   <= cnt_clr ? 32'd0 : cnt + 32'd1;
      case (state)
        IDLE: if (bus.valid) begin
          x         <= bus.p_x;
          y         <= bus.p_y;
          z         <= bus.p_z;
`ifndef GE_CACHED_RECOMPUTE_T_EN
          t         <= bus.p_t;
`endif
          error     <= bus.p_error;
          c_yplusx  <= '0;
          c_yminusx <= '0;
          c_z       <= '0;
          c_t2d     <= '0;
        end
        ADDSUB: begin
          c_yplusx  <= bus.add_res;
          c_yminusx <= bus.sub_res;
          c_z       <= z;
        end
`ifdef GE_CACHED_RECOMPUTE_T_EN
        MUL_T_WAIT: begin
          if (bus.mul_done) t <= bus.mul_res;
          else if (timeout) begin
            error <= 1'b1;
            c_t2d <= '0;
          end
        end
`endif
        MUL_WAIT: begin
          if (bus.mul_done) c_t2d <= bus.mul_res;
          else if (timeout) begin
            error <= 1'b1;
            c_t2d <= '0;
          end
        end
        default: ;
      endcase
    end
  end

  assign bus.c_yplusx  = c_yplusx;
  assign bus.c_yminusx = c_yminusx;
  assign bus.c_z       = c_z;
  assign bus.c_t2d     = c_t2d;
  assign bus.error     = error;
  assign bus.done      = (state == FIN);
  assign bus.busy      = (state != IDLE);

endmodule

// File: tb/tb_ge_p3_to_cached.sv
// tb/tb_ge_p3_to_cached.sv - self-checking bench for ge_p3_to_cached
module tb_ge_p3_to_cached;
  typedef logic [319:0] fe_t;

  localparam fe_t D2 = {
    32'sd9444199, 32'sd29715968, -32'sd6495438, -32'sd12551817, 32'sd15978800,
    32'sd229458, 32'sd13898782, -32'sd30745221, -32'sd5839606, -32'sd21827239
  };

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   cyc = 0;
  int   tests = 0;
  int   fails = 0;
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  ge_p3_to_cached_if bus ();
  ge_p3_to_cached_if tbus ();

  ge_p3_to_cached #(.MUL_TIMEOUT(0)) dut    (.clk(clk), .rst(rst), .bus(bus));
  ge_p3_to_cached #(.MUL_TIMEOUT(8)) dut_to (.clk(clk), .rst(rst), .bus(tbus));

  function automatic fe_t fe(input int v);
    fe_t r = '0;
    r[31:0] = v;
    return r;
  endfunction

  function automatic fe_t fe_add_m(input fe_t a, input fe_t b);
    fe_t r;
    for (int i = 0; i < 10; i++) r[32*i +: 32] = a[32*i +: 32] + b[32*i +: 32];
    return r;
  endfunction

  function automatic fe_t fe_sub_m(input fe_t a, input fe_t b);
    fe_t r;
    for (int i = 0; i < 10; i++) r[32*i +: 32] = a[32*i +: 32] - b[32*i +: 32];
    return r;
  endfunction

  // Stand-in multiplier: operand b scaled by limb0 of a (exact for the T values used here).
  function automatic fe_t mul_model(input fe_t a, input fe_t b);
    fe_t r;
    for (int i = 0; i < 10; i++) r[32*i +: 32] = b[32*i +: 32] * a[31:0];
    return r;
  endfunction

  task automatic chk(input string name, input fe_t act, input fe_t exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h want %h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  always_comb bus.add_res  = fe_add_m(bus.add_op_a, bus.add_op_b);
  always_comb bus.sub_res  = fe_sub_m(bus.sub_op_a, bus.sub_op_b);
  always_comb tbus.add_res = fe_add_m(tbus.add_op_a, tbus.add_op_b);
  always_comb tbus.sub_res = fe_sub_m(tbus.sub_op_a, tbus.sub_op_b);
  assign tbus.mul_res  = '0;
  assign tbus.mul_done = 1'b0;

  // Multiplier with a fixed response delay; it keeps running across a reset of the DUT.
  int  mul_lat = 2;
  int  mul_due = -1;
  fe_t mul_val = '0;
  always @(negedge clk) if (bus.mul_valid === 1'b1) begin
    mul_due = cyc + mul_lat;
    mul_val = mul_model(bus.mul_op_a, bus.mul_op_b);
  end
  always @(posedge clk) begin
    #1;
    bus.mul_done = (cyc == mul_due);
    bus.mul_res  = (cyc == mul_due) ? mul_val : '0;
  end

  // Reference model: job timeline derived from the accept cycle and multiplier delay.
  bit   pend = 0;
  int   s_cyc, d_cyc, mv_cyc;
  fe_t  m_x, m_y, m_t;
  fe_t  e_yp, e_ym, e_z, e_t2d;
  logic e_err;

  always @(negedge clk) begin
    logic live;
    live = pend && !e_err;
    chk("done", fe(int'(bus.done)), fe(int'(pend && cyc == d_cyc)));
    chk("busy", fe(int'(bus.busy)), fe(int'(pend && cyc > s_cyc && cyc <= d_cyc)));
    chk("mul_valid", fe(int'(bus.mul_valid)), fe(int'(live && cyc == mv_cyc)));
    chk("mul_op_a", bus.mul_op_a, (live && cyc >= mv_cyc && cyc < d_cyc) ? m_t : '0);
    chk("mul_op_b", bus.mul_op_b, (live && cyc >= mv_cyc && cyc < d_cyc) ? D2 : '0);
    chk("add_op_a", bus.add_op_a, (live && cyc == s_cyc + 1) ? m_y : '0);
    chk("sub_op_b", bus.sub_op_b, (live && cyc == s_cyc + 1) ? m_x : '0);
    if (pend && cyc == d_cyc) begin
      chk("c_yplusx", bus.c_yplusx, e_yp);
      chk("c_yminusx", bus.c_yminusx, e_ym);
      chk("c_z", bus.c_z, e_z);
      chk("c_t2d", bus.c_t2d, e_t2d);
      chk("error", fe(int'(bus.error)), fe(int'(e_err)));
    end
    if (rst) pend = 0;
    else if (bus.valid && !(pend && cyc <= d_cyc)) begin
      pend  = 1;
      s_cyc = cyc;
      m_x   = bus.p_x;
      m_y   = bus.p_y;
      m_t   = bus.p_t;
      e_err = bus.p_error;
      if (bus.p_error) begin
        d_cyc = cyc + 1;
        e_yp = '0; e_ym = '0; e_z = '0; e_t2d = '0;
      end else begin
        mv_cyc = cyc + 2;
        d_cyc  = cyc + 3 + mul_lat;
        e_yp   = fe_add_m(bus.p_y, bus.p_x);
        e_ym   = fe_sub_m(bus.p_y, bus.p_x);
        e_z    = bus.p_z;
        e_t2d  = mul_model(bus.p_t, D2);
      end
    end
  end

  task automatic drive(input fe_t x, input fe_t y, input fe_t z, input fe_t t,
                       input logic e, output int c0);
    c0 = cyc;
    bus.valid = 1'b1;
    bus.p_x = x; bus.p_y = y; bus.p_z = z; bus.p_t = t; bus.p_error = e;
    @(posedge clk); #1;
    bus.valid = 1'b0;
    bus.p_error = 1'b0;
  endtask

  task automatic wait_done(input int c0, input int maxc, output int n);
    n = -1;
    for (int i = 0; i < maxc; i++) begin
      @(negedge clk);
      if (bus.done) begin
        n = cyc - c0;
        break;
      end
    end
    if (n < 0) begin
      tests++; fails++;
      $display("FAIL wait_done: no done within %0d cycles", maxc);
    end
    @(posedge clk); #1;
  endtask

  initial begin
    int c0, c1, n;
    bus.valid = 1'b0; bus.p_error = 1'b0;
    bus.p_x = '0; bus.p_y = '0; bus.p_z = '0; bus.p_t = '0;
    tbus.valid = 1'b0; tbus.p_error = 1'b0;
    tbus.p_x = '0; tbus.p_y = '0; tbus.p_z = '0; tbus.p_t = '0;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    chk("rst_c_yplusx", bus.c_yplusx, '0);
    chk("rst_c_t2d", bus.c_t2d, '0);
    chk("rst_error", fe(int'(bus.error)), fe(0));

    // identity point
    mul_lat = 2;
    drive(fe(0), fe(1), fe(1), fe(0), 1'b0, c0);
    wait_done(c0, 50, n);
    chk("id_latency", fe(n), fe(5));
    chk("id_yplusx", bus.c_yplusx, fe(1));
    chk("id_yminusx", bus.c_yminusx, fe(1));
    chk("id_z", bus.c_z, fe(1));
    chk("id_t2d", bus.c_t2d, fe(0));

    // slow multiplier, T=1
    mul_lat = 20;
    drive(fe(1), fe(5), fe(1), fe(1), 1'b0, c0);
    wait_done(c0, 100, n);
    chk("slow_latency", fe(n), fe(23));
    chk("slow_yplusx", bus.c_yplusx, fe(6));
    chk("slow_yminusx", bus.c_yminusx, fe(4));
    chk("slow_t2d", bus.c_t2d, D2);

    // forwarded decode error
    drive(fe(7), fe(8), fe(1), fe(9), 1'b1, c0);
    wait_done(c0, 20, n);
    chk("err_latency", fe(n), fe(1));
    chk("err_flag", fe(int'(bus.error)), fe(1));
    chk("err_yplusx", bus.c_yplusx, '0);

    // valid while busy and during FIN is ignored; next IDLE cycle is accepted
    mul_lat = 3;
    drive(fe(2), fe(3), fe(1), fe(2), 1'b0, c0);
    repeat (3) @(posedge clk);
    #1 drive(fe(9), fe(9), fe(9), fe(9), 1'b0, c1);
    @(posedge clk); #1;
    drive(fe(11), fe(12), fe(13), fe(14), 1'b1, c1);
    chk("hold_yplusx", bus.c_yplusx, fe(5));
    chk("hold_error", fe(int'(bus.error)), fe(0));
    drive(fe(4), fe(1), fe(1), fe(3), 1'b0, c0);
    wait_done(c0, 50, n);
    chk("next_latency", fe(n), fe(6));
    chk("next_yminusx", bus.c_yminusx, fe(32'hFFFF_FFFD));

    // reset during MUL_WAIT, late mul_done ignored
    mul_lat = 4;
    drive(fe(1), fe(2), fe(1), fe(1), 1'b0, c0);
    repeat (2) @(posedge clk);
    #1 rst = 1'b1;
    @(posedge clk); #1 rst = 1'b0;
    chk("mid_rst_busy", fe(int'(bus.busy)), fe(0));
    chk("mid_rst_yplusx", bus.c_yplusx, '0);
    repeat (5) @(posedge clk);
    #1;
    mul_lat = 2;
    drive(fe(3), fe(4), fe(1), fe(1), 1'b0, c0);
    wait_done(c0, 50, n);
    chk("after_rst_latency", fe(n), fe(5));
    chk("after_rst_yplusx", bus.c_yplusx, fe(7));
    chk("after_rst_t2d", bus.c_t2d, D2);

    // multiplier timeout on the MUL_TIMEOUT=8 instance
    c0 = cyc;
    tbus.valid = 1'b1;
    tbus.p_x = fe(1); tbus.p_y = fe(5); tbus.p_z = fe(1); tbus.p_t = fe(1);
    @(posedge clk); #1 tbus.valid = 1'b0;
    n = -1;
    for (int i = 0; i < 50; i++) begin
      @(negedge clk);
      if (tbus.done) begin
        n = cyc - c0;
        break;
      end
    end
    chk("to_latency", fe(n), fe(10));
    chk("to_error", fe(int'(tbus.error)), fe(1));
    chk("to_t2d", tbus.c_t2d, '0);
    chk("to_yplusx", tbus.c_yplusx, fe(6));
    @(posedge clk); #1;
    chk("to_idle", fe(int'(tbus.busy)), fe(0));

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
